// File: rtl/digest_reader_if.sv
// rtl/digest_reader_if.sv - digest beat stream bundle between reader and consumer
interface digest_reader_if #(
  parameter int OUT_W = 8
);
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/digest_reader.sv
// rtl/digest_reader.sv - captures final SHA-256 state and streams it MSB-first in OUT_W beats
module digest_reader #(
  parameter int OUT_W = 8,
  parameter int CNT_W = 6
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_hash_done,
  input  logic [255:0]        i_digest_in,
  digest_reader_if.master     o_stream,
  output logic                o_busy,
  output logic                o_overrun
);

  localparam int               BEATS    = 256 / OUT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [0:0] {ST_IDLE, ST_SEND} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [255:0]       r_shreg;
  logic [255:0]       w_shreg_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               r_overrun;
  logic               w_overrun_next;
  logic               w_sending;
  logic               w_last;
  logic               w_fire;

  // Outputs derive only from registered state, so out_ready never reaches out_valid.
  assign w_sending          = (r_state == ST_SEND);
  assign w_last             = w_sending && (r_cnt == LAST_CNT);
  assign w_fire             = w_sending && o_stream.out_ready;
  assign o_stream.out_valid = w_sending;
  assign o_stream.out_last  = w_last;
  assign o_stream.out_data  = r_shreg[255 -: OUT_W];
  assign o_busy             = w_sending;
  assign o_overrun          = r_overrun;

  // Next-state: capture in IDLE, shift on each accepted beat in SEND.
  always_comb begin
    w_state_next   = r_state;
    w_shreg_next   = r_shreg;
    w_cnt_next     = r_cnt;
    w_overrun_next = r_overrun;
    case (r_state)
      ST_IDLE: begin
        if (i_hash_done) begin
          w_shreg_next = i_digest_in;
          w_cnt_next   = '0;
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        // A new digest cannot be taken mid-stream; flag it and keep sending the current one.
        if (i_hash_done) begin
          w_overrun_next = 1'b1;
        end
        if (w_fire) begin
          w_shreg_next = r_shreg << OUT_W;
          if (w_last) begin
            // Counter parks on the last index so it never wraps within a digest.
            w_state_next = ST_IDLE;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any partially sent digest.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shreg   <= w_shreg_next;
      r_cnt     <= w_cnt_next;
      r_overrun <= w_overrun_next;
    end
  end

endmodule

// File: tb/tb_digest_reader.sv
// tb/tb_digest_reader.sv - directed self-checking bench for digest_reader
module tb_digest_reader;

  localparam logic [255:0] DIG_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  logic         clk = 1'b0;
  logic         rst;
  logic         hash_done;
  logic [255:0] digest_in;
  logic         busy;
  logic         overrun;
  logic         hash_done32;
  logic [255:0] digest_in32;
  logic         busy32;
  logic         overrun32;

  int n_checks = 0;
  int n_errors = 0;
  int idx;
  logic rdy;

  digest_reader_if #(.OUT_W(8))  s8 ();
  digest_reader_if #(.OUT_W(32)) s32 ();

  digest_reader #(.OUT_W(8), .CNT_W(6)) u_dut8 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_hash_done (hash_done),
    .i_digest_in (digest_in),
    .o_stream    (s8),
    .o_busy      (busy),
    .o_overrun   (overrun)
  );

  digest_reader #(.OUT_W(32), .CNT_W(6)) u_dut32 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_hash_done (hash_done32),
    .i_digest_in (digest_in32),
    .o_stream    (s32),
    .o_busy      (busy32),
    .o_overrun   (overrun32)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input logic [255:0] d, input int i);
    return d[255 - 8*i -: 8];
  endfunction

  function automatic logic [31:0] word_of(input logic [255:0] d, input int i);
    return d[255 - 32*i -: 32];
  endfunction

  task automatic capture8(input logic [255:0] d);
    digest_in = d;
    hash_done = 1'b1;
    tick();
    hash_done = 1'b0;
    digest_in = ~d;
  endtask

  // Consume beats first..last with out_ready held high, checking each one.
  task automatic stream8(input string tag, input logic [255:0] d, input int first, input int last);
    s8.out_ready = 1'b1;
    for (int i = first; i <= last; i++) begin
      check({tag, "_valid"}, s8.out_valid, 1'b1);
      check({tag, "_data"}, s8.out_data, byte_of(d, i));
      check({tag, "_last"}, s8.out_last, (i == 31));
      tick();
    end
  endtask

  initial begin
    rst          = 1'b1;
    hash_done    = 1'b0;
    digest_in    = '0;
    hash_done32  = 1'b0;
    digest_in32  = '0;
    s8.out_ready  = 1'b0;
    s32.out_ready = 1'b0;

    // 1: reset
    tick();
    tick();
    check("rst_valid", s8.out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_data", s8.out_data, 8'h00);
    check("rst_last", s8.out_last, 1'b0);
    rst = 1'b0;
    tick();

    // 2: "abc" digest at full rate
    s8.out_ready = 1'b1;
    capture8(DIG_ABC);
    check("abc_busy", busy, 1'b1);
    check("abc_first", s8.out_data, 8'hba);
    stream8("abc", DIG_ABC, 0, 31);
    check("abc_done_valid", s8.out_valid, 1'b0);
    check("abc_done_busy", busy, 1'b0);
    check("abc_done_last", s8.out_last, 1'b0);
    check("abc_overrun", overrun, 1'b0);

    // 3: random backpressure
    s8.out_ready = 1'b0;
    tick();
    capture8(DIG_EMPTY);
    idx = 0;
    for (int c = 0; c < 400 && idx < 32; c++) begin
      check("bp_valid", s8.out_valid, 1'b1);
      check("bp_data", s8.out_data, byte_of(DIG_EMPTY, idx));
      check("bp_last", s8.out_last, (idx == 31));
      rdy = 1'($urandom_range(0, 1));
      s8.out_ready = rdy;
      tick();
      if (rdy) idx++;
    end
    check("bp_count", idx, 32);
    check("bp_done_busy", busy, 1'b0);

    // 4: overrun at beat 5
    capture8(DIG_ABC);
    stream8("ovr_pre", DIG_ABC, 0, 4);
    check("ovr_b5_data", s8.out_data, byte_of(DIG_ABC, 5));
    digest_in = DIG_EMPTY;
    hash_done = 1'b1;
    tick();
    hash_done = 1'b0;
    check("ovr_set", overrun, 1'b1);
    check("ovr_busy", busy, 1'b1);
    stream8("ovr_post", DIG_ABC, 6, 31);
    check("ovr_done_busy", busy, 1'b0);
    tick();
    tick();
    check("ovr_sticky", overrun, 1'b1);
    check("ovr_idle_valid", s8.out_valid, 1'b0);

    // 5: reset mid-stream at beat 10, then rst+hash_done together, then restart
    capture8(DIG_ABC);
    stream8("mid", DIG_ABC, 0, 9);
    check("mid_b10_data", s8.out_data, byte_of(DIG_ABC, 10));
    rst = 1'b1;
    tick();
    check("mid_rst_valid", s8.out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_overrun", overrun, 1'b0);
    check("mid_rst_data", s8.out_data, 8'h00);
    digest_in = DIG_ABC;
    hash_done = 1'b1;
    tick();
    rst = 1'b0;
    hash_done = 1'b0;
    tick();
    check("rst_wins_busy", busy, 1'b0);
    check("rst_wins_valid", s8.out_valid, 1'b0);
    capture8(DIG_EMPTY);
    stream8("restart", DIG_EMPTY, 0, 31);
    check("restart_busy", busy, 1'b0);
    check("restart_overrun", overrun, 1'b0);

    // 6: 32-bit beats
    s32.out_ready = 1'b1;
    digest_in32 = DIG_ABC;
    hash_done32 = 1'b1;
    tick();
    hash_done32 = 1'b0;
    digest_in32 = '0;
    check("w32_first", s32.out_data, 32'hba7816bf);
    for (int i = 0; i < 8; i++) begin
      check("w32_valid", s32.out_valid, 1'b1);
      check("w32_data", s32.out_data, word_of(DIG_ABC, i));
      check("w32_last", s32.out_last, (i == 7));
      tick();
    end
    check("w32_done_valid", s32.out_valid, 1'b0);
    check("w32_done_busy", busy32, 1'b0);
    check("w32_overrun", overrun32, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
